// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port request/acknowledge arbiter in front of a single-port
// data memory. The winning request is registered, presented to the memory for
// one cycle (ACCESS), then read data is captured and a one-cycle ack returned.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          PRIO_FIXED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state;
  logic   last_grant;
  logic   elig0;
  logic   elig1;
  logic   pick1;

  // Eligibility with ack blanking, then winner selection (1 = m1)
  always_comb begin
    elig0 = m0_req & ~m0_ack;
    elig1 = m1_req & ~m1_ack;
    pick1 = 1'b0;
    if (elig0 && elig1) begin
      pick1 = PRIO_FIXED ? 1'b0 : ~last_grant;
    end else begin
      pick1 = elig1;
    end
  end

  // Two-state arbitration FSM; every output is a register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          if (elig0 || elig1) begin
            mem_addr   <= pick1 ? m1_addr  : m0_addr;
            mem_wdata  <= pick1 ? m1_wdata : m0_wdata;
            mem_read   <= pick1 ? ~m1_we   : ~m0_we;
            mem_write  <= pick1 ? m1_we    : m0_we;
            grant_id   <= pick1;
            last_grant <= pick1;
            busy       <= 1'b1;
            state      <= ACCESS;
          end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_read) begin
            if (grant_id) m1_rdata <= mem_rdata;
            else          m0_rdata <= mem_rdata;
          end
          if (grant_id) m1_ack <= 1'b1;
          else          m0_ack <= 1'b1;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port request/acknowledge arbiter that shares the single-port data memory between two requesters. Port m0 is the pipeline MEM stage; port m1 is a secondary master such as a loader or debug/DMA engine. The block registers the winning request, drives the memory control/address/data lines for one cycle, then captures read data and returns a one-cycle acknowledge. It sits directly in front of the data memory's Address/Write_data/MemRead/MemWrite/Mem_data interface.

Parameters:
ADDR_WIDTH, 32, width of requester and memory address
DATA_WIDTH, 32, width of write/read data
PRIO_FIXED, 0, 0 = round-robin between m0/m1; 1 = m0 always wins a tie

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
m0_req  input  1  m0 request; held until m0_ack
m0_we  input  1  m0 1 = write, 0 = read
m0_addr  input  ADDR_WIDTH  m0 byte address
m0_wdata  input  DATA_WIDTH  m0 write data
m0_ack  output  1  one-cycle completion pulse to m0
m0_rdata  output  DATA_WIDTH  m0 read data, valid when m0_ack=1
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0, for port m1
mem_addr  output  ADDR_WIDTH  to memory Address
mem_wdata  output  DATA_WIDTH  to memory Write_data
mem_read  output  1  to memory MemRead
mem_write  output  1  to memory MemWrite
mem_rdata  input  DATA_WIDTH  from memory Mem_data (combinational read)
busy  output  1  1 while in ACCESS
grant_id  output  1  port currently or last served (0 = m0, 1 = m1)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Reset values: all outputs are 0, state = IDLE, last_grant = 1, so m0 wins the first tie.
- Reset affects outputs immediately. Asserting reset mid-ACCESS drops mem_write before the next edge, so the in-flight write is aborted, not performed.
- FSM has two states, IDLE and ACCESS.
- IDLE: an eligible request is mX_req=1 and mX_ack=0 in this cycle.
  - Blanking rule: a requester whose ack is high this cycle is ignored, because it drops req next cycle.
  - One eligible port wins.
  - Both eligible: with PRIO_FIXED=1, m0 wins. With PRIO_FIXED=0, the port != last_grant wins.
  - On the winning edge: register mem_addr/mem_wdata from the winner; mem_read = ~we; mem_write = we; grant_id = winner; last_grant = winner; busy = 1; go to ACCESS.
  - No eligible request: mem_read = mem_write = 0; stay in IDLE. mem_addr/mem_wdata hold their last values.
- ACCESS lasts exactly one cycle. The memory sees stable controls for a full cycle, and a write commits on the edge that leaves ACCESS.
  - On that edge: if it was a read, mX_rdata <= mem_rdata; if it was a write, mX_rdata holds its previous value.
  - Also on that edge: mX_ack <= 1 for the winner; mem_read = mem_write = 0; busy = 0; go to IDLE.
- Acks are single-cycle pulses; mX_ack deasserts on the following edge. mX_rdata holds until that port's next read completes.
- Latency: req sampled at edge N, memory access during cycle N+1, ack/rdata visible in cycle N+2. Maximum throughput is one access per 2 cycles.
- Fairness: with both ports requesting continuously and PRIO_FIXED=0, grants strictly alternate. Worst-case wait is 4 cycles.
- The arbiter performs no address decode or width conversion. Addresses pass through unchanged; word selection is the memory's job.
- A requester changing addr/wdata/we while waiting has no effect once its request has been latched. Before latching, the most recent values at the winning edge are used.

Test Plan:
1. Reset low for 3 cycles, then high -> all outputs 0, busy=0, mem_read=mem_write=0.
2. m0 write addr 0x80, data 0xDEADBEEF, then m0 read 0x80 -> mem_write=1 for exactly one cycle with mem_addr=0x80; write ack 2 cycles after req; read returns m0_rdata=0xDEADBEEF with m0_ack pulse.
3. m0 and m1 both request reads at the same edge, held continuously, PRIO_FIXED=0 -> grant order m0, m1, m0, m1; each ack is 1 cycle wide; acks every 2 cycles.
4. Same stimulus with PRIO_FIXED=1, m1 held requesting -> m0 served each time it is eligible. m1 is served only on edges where m0 is blanked by its ack or idle.
5. m1 write addr 0x10 data 0x55 granted, reset pulled low mid-ACCESS -> mem_write falls immediately; readback of 0x10 after reset shows the old value; no m1_ack.
6. m0 read of addr 0x04 with mem_rdata modelled as 0x0B; m0 changes m0_addr to 0x08 in the ACCESS cycle -> mem_addr stays 0x04; m0_rdata=0x0B.
